// File: rtl/prop_monitor.sv
// rtl/prop_monitor.sv - protocol monitor for a stage sequencer driving a program counter.
// Tracks the stage cycle, checks PC load timing and value, counts completed instructions.
module prop_monitor #(
  parameter int NSTAGE = 5,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      stage,
  input  logic            pcWrite,
  input  logic [31:0]     pcValue,
  input  logic [31:0]     npcIn,
  output logic [CNTW-1:0] instrCount,
  output logic [31:0]     lastPc,
  output logic            errStage,
  output logic            errWrite,
  output logic            errNpc,
  output logic            errPc,
  output logic            errAny,
  output logic [1:0]      state
);

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;
  localparam logic [2:0] LAST  = 3'(NSTAGE - 1);

  logic [1:0]  st, nst;
  logic [2:0]  prev_stage;
  logic [2:0]  want_stage;
  logic [31:0] exp_pc;
  logic        checking, in_range;
  logic        set_stage, set_write, set_npc, set_pc, any_set;
  logic        load, commit;

  // Violation detection for the current sample; FAULT and SYNC run no checks.
  always_comb begin
    checking   = (st == TRACK) || (st == CHECK);
    in_range   = int'(stage) < NSTAGE;
    want_stage = (prev_stage == LAST) ? 3'd0 : prev_stage + 3'd1;
    set_stage  = checking && (!in_range || (stage != want_stage));
    set_write  = (st == TRACK) && (pcWrite != (stage == LAST));
    load       = (st == TRACK) && pcWrite && (stage == LAST);
    set_npc    = load && (npcIn != pcValue + 32'd1);
    set_pc     = (st == CHECK) && (pcValue != exp_pc);
    any_set    = set_stage || set_write || set_npc || set_pc;
  end

  always_comb begin
    nst = st;
    case (st)
      SYNC:    nst = (stage == 3'd0) ? TRACK : SYNC;
      TRACK:   nst = any_set ? FAULT : (load ? CHECK : TRACK);
      CHECK:   nst = any_set ? FAULT : TRACK;
      default: nst = FAULT;
    endcase
  end

  // A CHECK cycle only retires the instruction when it raised no new error.
  always_comb begin
    commit = (st == CHECK) && !any_set;
    state  = st;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= SYNC;
      prev_stage <= 3'd0;
      exp_pc     <= 32'd0;
      instrCount <= '0;
      lastPc     <= 32'd0;
      errStage   <= 1'b0;
      errWrite   <= 1'b0;
      errNpc     <= 1'b0;
      errPc      <= 1'b0;
      errAny     <= 1'b0;
    end else begin
      st     <= nst;
      errAny <= errStage | errWrite | errNpc | errPc;
      if (st != FAULT) prev_stage <= stage;
      if (set_stage) errStage <= 1'b1;
      if (set_write) errWrite <= 1'b1;
      if (set_npc)   errNpc   <= 1'b1;
      if (set_pc)    errPc    <= 1'b1;
      if (load)      exp_pc   <= npcIn;
      if (commit) begin
        lastPc <= pcValue;
        if (instrCount != {CNTW{1'b1}}) instrCount <= instrCount + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_prop_monitor.sv
// tb/tb_prop_monitor.sv - table-driven bench for prop_monitor with hand-written reset and saturation sequences.
module tb_prop_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stage;
  logic        pcWrite;
  logic [31:0] pcValue, npcIn;
  logic [15:0] instrCount;
  logic [31:0] lastPc;
  logic        errStage, errWrite, errNpc, errPc, errAny;
  logic [1:0]  state;
  logic [1:0]  cnt2;
  logic [31:0] last2;
  logic        es2, ew2, en2, ep2, ea2;
  logic [1:0]  st2;

  always #5 clk = ~clk;

  prop_monitor dut (
    .clk(clk), .rst(rst), .stage(stage), .pcWrite(pcWrite), .pcValue(pcValue), .npcIn(npcIn),
    .instrCount(instrCount), .lastPc(lastPc), .errStage(errStage), .errWrite(errWrite),
    .errNpc(errNpc), .errPc(errPc), .errAny(errAny), .state(state)
  );

  prop_monitor #(.NSTAGE(5), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .stage(stage), .pcWrite(pcWrite), .pcValue(pcValue), .npcIn(npcIn),
    .instrCount(cnt2), .lastPc(last2), .errStage(es2), .errWrite(ew2),
    .errNpc(en2), .errPc(ep2), .errAny(ea2), .state(st2)
  );

  typedef struct {
    logic        r;
    logic [2:0]  s;
    logic        w;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [15:0] cnt;
    logic [31:0] last;
    logic [3:0]  flags;
    logic        any;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total  = 0;

  task automatic add(input logic r, input logic [2:0] s, input logic w, input logic [31:0] pc,
                     input logic [31:0] npc, input logic [15:0] cnt, input logic [31:0] last,
                     input logic [3:0] flags, input logic any, input logic [1:0] st);
    vec_t v;
    v.r = r; v.s = s; v.w = w; v.pc = pc; v.npc = npc;
    v.cnt = cnt; v.last = last; v.flags = flags; v.any = any; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [2:0] s, input logic w,
                      input logic [31:0] pc, input logic [31:0] npc);
    rst = r; stage = s; pcWrite = w; pcValue = pc; npcIn = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  function automatic logic [63:0] pack_dut();
    return {9'd0, state, errAny, errPc, errNpc, errWrite, errStage, lastPc, instrCount};
  endfunction

  // One instruction cycle from TRACK with previous stage 0; leaves the block in TRACK.
  task automatic instr(input logic [31:0] pc);
    step(0, 3'd1, 0, pc, 32'd0);
    step(0, 3'd2, 0, pc, 32'd0);
    step(0, 3'd3, 0, pc, 32'd0);
    step(0, 3'd4, 1, pc, pc + 32'd1);
    step(0, 3'd0, 0, pc + 32'd1, 32'd0);
  endtask

  initial begin
    // basic cycle, then PC wrap at 0xFFFFFFFF
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 2, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 3, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 4, 1, 32'h10, 32'h11, 0, 0, 4'h0, 0, 2);
    add(0, 0, 0, 32'h11, 0, 1, 32'h11, 4'h0, 0, 1);
    add(0, 1, 0, 32'h11, 0, 1, 32'h11, 4'h0, 0, 1);
    add(0, 2, 0, 32'h11, 0, 1, 32'h11, 4'h0, 0, 1);
    add(0, 3, 0, 32'h11, 0, 1, 32'h11, 4'h0, 0, 1);
    add(0, 4, 1, 32'hFFFFFFFF, 32'h0, 1, 32'h11, 4'h0, 0, 2);
    add(0, 0, 0, 32'h0, 0, 2, 32'h0, 4'h0, 0, 1);
    // step skip 1 -> 3
    add(0, 1, 0, 0, 0, 2, 0, 4'h0, 0, 1);
    add(0, 3, 0, 0, 0, 2, 0, 4'h1, 0, 3);
    add(0, 4, 0, 0, 0, 2, 0, 4'h1, 1, 3);
    // early pcWrite after one good instruction
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 2, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 3, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 4, 1, 32'h5, 32'h6, 0, 0, 4'h0, 0, 2);
    add(0, 0, 0, 32'h6, 0, 1, 32'h6, 4'h0, 0, 1);
    add(0, 1, 0, 32'h6, 0, 1, 32'h6, 4'h0, 0, 1);
    add(0, 2, 1, 32'h6, 0, 1, 32'h6, 4'h2, 0, 3);
    add(0, 3, 0, 32'h6, 0, 1, 32'h6, 4'h2, 1, 3);
    // bad next-PC
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 2, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 3, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 4, 1, 32'h20, 32'h22, 0, 0, 4'h4, 0, 3);
    add(0, 0, 0, 32'h21, 0, 0, 0, 4'h4, 1, 3);
    // PC did not follow the captured next-PC
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 2, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 3, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 4, 1, 32'h30, 32'h31, 0, 0, 4'h0, 0, 2);
    add(0, 0, 0, 32'h30, 0, 0, 0, 4'h8, 0, 3);
    add(0, 1, 0, 32'h30, 0, 0, 0, 4'h8, 1, 3);
    // repeated stage plus early write in one cycle
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 4'h3, 0, 3);
    // out-of-range stage
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 7, 0, 0, 0, 0, 0, 4'h1, 0, 3);
    // missing write at the last stage
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 2, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 3, 0, 0, 0, 0, 0, 4'h0, 0, 1);
    add(0, 4, 0, 0, 0, 0, 0, 4'h2, 0, 3);
    // SYNC ignores everything until stage 0
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 3, 1, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 5, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].s, vecs[i].w, vecs[i].pc, vecs[i].npc);
      check($sformatf("vec%0d", i), pack_dut(),
            {9'd0, vecs[i].st, vecs[i].any, vecs[i].flags, vecs[i].last, vecs[i].cnt});
    end

    // reset during CHECK after two retired instructions, then realign
    step(1, 3'd0, 0, 0, 0);
    step(0, 3'd0, 0, 0, 0);
    instr(32'h40);
    instr(32'h41);
    step(0, 3'd1, 0, 32'h42, 0);
    step(0, 3'd2, 0, 32'h42, 0);
    step(0, 3'd3, 0, 32'h42, 0);
    step(0, 3'd4, 1, 32'h42, 32'h43);
    check("in_check", pack_dut(), {9'd0, 2'd2, 1'b0, 4'h0, 32'h42, 16'd2});
    step(1, 3'd0, 0, 32'h43, 0);
    check("rst_in_check", pack_dut(), 64'd0);
    step(0, 3'd2, 0, 0, 0);
    check("sync_wait", pack_dut(), 64'd0);
    step(0, 3'd0, 0, 0, 0);
    check("realign", pack_dut(), {9'd0, 2'd1, 1'b0, 4'h0, 32'h0, 16'd0});
    instr(32'h100);
    check("recount", pack_dut(), {9'd0, 2'd1, 1'b0, 4'h0, 32'h101, 16'd1});
    instr(32'h101);
    instr(32'h102);
    check("sat_at_max", 64'(cnt2), 64'd3);
    instr(32'h103);
    check("count4", pack_dut(), {9'd0, 2'd1, 1'b0, 4'h0, 32'h104, 16'd4});
    check("sat_hold", 64'(cnt2), 64'd3);
    check("sat_last", 64'(last2), 64'h104);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prop_monitor.md
PROP_MONITOR -- requirements
Module: prop_monitor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: all state changes on the rising edge of clk, and reset acts only at that edge.
REQ-002 Parameter: NSTAGE, default 5, number of stage values in one instruction cycle (legal stage values 0..NSTAGE-1).
REQ-003 Parameter: CNTW, default 16, width of the instruction counter.
REQ-004 Port: clk  input  1  system clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: stage  input  3  stage index from the stage sequencer.
REQ-007 Port: pcWrite  input  1  PC load enable from the stage sequencer.
REQ-008 Port: pcValue  input  32  current program counter output.
REQ-009 Port: npcIn  input  32  next-PC value presented to the program counter input.
REQ-010 Port: instrCount  output  CNTW  completed instruction cycles, saturating.
REQ-011 Port: lastPc  output  32  PC value captured at the most recent checked load.
REQ-012 Port: errStage  output  1  sticky flag: illegal stage value or illegal stage step.
REQ-013 Port: errWrite  output  1  sticky flag: pcWrite asserted outside stage NSTAGE-1, or missing in stage NSTAGE-1.
REQ-014 Port: errNpc  output  1  sticky flag: at a load, npcIn != pcValue+1.
REQ-015 Port: errPc  output  1  sticky flag: PC after a load != the captured npcIn.
REQ-016 Port: errAny  output  1  OR of the four error flags, registered.
REQ-017 Port: state  output  2  FSM state encoding, for debug.

Function
REQ-018 FSM states SHALL be: SYNC=0, TRACK=1, CHECK=2, FAULT=3.
REQ-019 SYNC SHALL wait for stage==0 and then go to TRACK on the next edge; no checks run while in SYNC.
REQ-020 In TRACK, each cycle the block SHALL require stage == (previous stage+1) mod NSTAGE; otherwise it sets errStage.
REQ-021 A stage value >= NSTAGE SHALL set errStage in any state except SYNC.
REQ-022 In TRACK, pcWrite=1 with stage!=NSTAGE-1 SHALL set errWrite.
REQ-023 In TRACK, pcWrite=0 with stage==NSTAGE-1 SHALL set errWrite.
REQ-024 On a TRACK edge with pcWrite=1 and stage==NSTAGE-1, the block SHALL:
- capture npcIn into an internal expected register;
- compare npcIn with pcValue+1 (32-bit wrap, 0xFFFFFFFF+1=0) and set errNpc on mismatch;
- go to CHECK.
REQ-025 In CHECK (exactly one cycle), the block SHALL:
- compare pcValue with the expected register, and set errPc on mismatch;
- load lastPc with pcValue;
- increment instrCount, saturating at 2^CNTW-1;
- return to TRACK, still applying the stage-step check of REQ-020.
REQ-026 Latency: errNpc and errStage SHALL be visible one cycle after the offending sample; errPc one cycle after CHECK; errAny one cycle after the flag it reflects.
REQ-027 Any error flag becoming set SHALL move the FSM to FAULT on the same edge.
REQ-028 FAULT SHALL be absorbing until rst: no further checks, counter frozen, lastPc frozen.
REQ-029 Error flags SHALL be sticky and clear only on rst.
REQ-030 If several violations occur in one cycle, every corresponding flag SHALL be set on that edge.
REQ-031 Stage sequence wrap from NSTAGE-1 to 0 SHALL be legal; any repeat of the same stage value is a step error.

Reset
REQ-032 When rst=1 at an edge, the block SHALL set: state=SYNC, instrCount=0, lastPc=0, all error flags=0, errAny=0, expected register=0, previous-stage register=0.
REQ-033 Reset asserted mid-cycle (any state, including CHECK or FAULT) SHALL abort the operation with no partial update, and SYNC resumes re-alignment afterwards.

Verification
REQ-034 After reset, stage 0,1,2,3,4 with pcWrite=1 only at stage 4, pcValue=0x10, npcIn=0x11, then pcValue=0x11 -> instrCount=1, lastPc=0x11, all flags=0.
REQ-035 Stage sequence 0,1,3 -> errStage=1 one cycle after the stage 3 sample, state=FAULT, errAny=1 next cycle.
REQ-036 pcWrite=1 at stage 2 -> errWrite=1 and FAULT; instrCount stays at its prior value.
REQ-037 At the stage-4 load, pcValue=0x20 and npcIn=0x22 -> errNpc=1; pcValue=0xFFFFFFFF with npcIn=0x0 -> no error.
REQ-038 Load captures npcIn=0x31, but the next-cycle pcValue=0x30 -> errPc=1 and lastPc unchanged.
REQ-039 Run 3 good instruction cycles, assert rst during CHECK, then release -> all outputs 0, state=SYNC; the block re-aligns at the next stage 0 and counts from 0.
